rom_serial_deserializer: RTL and testbench

Upstream feeder for the ROM stream loader. Receives program words from an external host over a 3-wire serial link (chip-select, serial clock, data; MSB first), assembles them into DATA_WIDTH-bit words, and presents each word to the loader on its `load` / `input_data` / `sck` / `ack` handshake. It double-buffers one word so the host can keep shifting while the loader writes to ROM, and flags overruns when the host outpaces the loader.

---
 rtl/rom_serial_deserializer.sv | 125 ++++++++++++
 tb/tb_rom_serial_deserializer.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_serial_deserializer.sv
// Serial-to-parallel front end for the ROM stream loader: synchronises a 3-wire host link,
// assembles MSB-first words and double-buffers one word behind a strobe/ack handshake.
module rom_serial_deserializer #(
  parameter int DATA_WIDTH  = 16,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   ser_cs_n,
  input  logic                   ser_sck,
  input  logic                   ser_data,
  output logic                   load,
  output logic [DATA_WIDTH-1:0]  word_data,
  output logic                   word_strobe,
  input  logic                   ack,
  output logic [COUNT_WIDTH-1:0] word_count,
  output logic                   overrun
);

  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} state_e;

  state_e                 state_q, state_d;
  logic                   cs_s1_q, cs_s2_q;
  logic                   sck_s1_q, sck_s2_q, sck_s3_q;
  logic                   dat_s1_q, dat_s2_q;
  logic [DATA_WIDTH-1:0]  shift_q, shift_d;
  logic [DATA_WIDTH-1:0]  word_q, word_d;
  logic [BW-1:0]          bit_cnt_q, bit_cnt_d;
  logic                   strobe_q, strobe_d;
  logic                   ovr_q, ovr_d;
  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                   sck_rise, shift_en, word_done, ack_take;

  // Pin synchronisers; cs flops idle high so reset reads as "deselected".
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cs_s1_q  <= 1'b1;
      cs_s2_q  <= 1'b1;
      sck_s1_q <= 1'b0;
      sck_s2_q <= 1'b0;
      sck_s3_q <= 1'b0;
      dat_s1_q <= 1'b0;
      dat_s2_q <= 1'b0;
    end else begin
      cs_s1_q  <= ser_cs_n;
      cs_s2_q  <= cs_s1_q;
      sck_s1_q <= ser_sck;
      sck_s2_q <= sck_s1_q;
      sck_s3_q <= sck_s2_q;
      dat_s1_q <= ser_data;
      dat_s2_q <= dat_s1_q;
    end
  end

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    word_d    = word_q;
    bit_cnt_d = bit_cnt_q;
    strobe_d  = strobe_q;
    ovr_d     = ovr_q;
    cnt_d     = cnt_q;
    sck_rise  = sck_s2_q & ~sck_s3_q;
    shift_en  = (state_q == ACTIVE) && !cs_s2_q && sck_rise;
    word_done = shift_en && (bit_cnt_q == BW'(DATA_WIDTH-1));
    ack_take  = (state_q != IDLE) && ack && strobe_q;

    case (state_q)
      IDLE: if (!cs_s2_q) begin
        state_d   = ACTIVE;
        bit_cnt_d = '0;
        cnt_d     = '0;
        ovr_d     = 1'b0;
        strobe_d  = 1'b0;
      end
      // An ack landing on the deselect cycle empties the buffer, so skip DRAIN then.
      ACTIVE: if (cs_s2_q) state_d = (strobe_q && !ack) ? DRAIN : IDLE;
      DRAIN:  if (ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (shift_en) begin
      shift_d   = {shift_q[DATA_WIDTH-2:0], dat_s2_q};
      bit_cnt_d = word_done ? '0 : bit_cnt_q + 1'b1;
    end
    if (ack_take) begin
      cnt_d    = cnt_q + 1'b1;
      strobe_d = 1'b0;
    end
    if (word_done) begin
      word_d   = {shift_q[DATA_WIDTH-2:0], dat_s2_q};
      strobe_d = 1'b1;
      if (strobe_q && !ack) ovr_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      word_q    <= '0;
      bit_cnt_q <= '0;
      strobe_q  <= 1'b0;
      ovr_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      word_q    <= word_d;
      bit_cnt_q <= bit_cnt_d;
      strobe_q  <= strobe_d;
      ovr_q     <= ovr_d;
      cnt_q     <= cnt_d;
    end
  end

  assign load        = (state_q != IDLE);
  assign word_data   = word_q;
  assign word_strobe = strobe_q;
  assign word_count  = cnt_q;
  assign overrun     = ovr_q;

endmodule

// File: tb/tb_rom_serial_deserializer.sv
// Scoreboarded bench: host bit-bangs words, a loader model acks, and a monitor checks every
// consumed word against the queue of words the host was expected to deliver.
module tb_rom_serial_deserializer;
  localparam int DW = 16;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          reset, ser_cs_n, ser_sck, ser_data, ack;
  logic          load, word_strobe, overrun;
  logic [DW-1:0] word_data;
  logic [CW-1:0] word_count;

  int            errors = 0;
  int            checks = 0;
  logic [DW-1:0] exp_q[$];
  bit            ld_auto = 1'b0;
  bit            ld_rand = 1'b0;
  int            ld_delay = 3;

  rom_serial_deserializer #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .ser_cs_n(ser_cs_n), .ser_sck(ser_sck), .ser_data(ser_data),
    .load(load), .word_data(word_data), .word_strobe(word_strobe), .ack(ack),
    .word_count(word_count), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // mode 0: plain; 1: ack in the completion cycle of this word; 2: check strobe timing.
  task automatic send_word(input logic [DW-1:0] w, input int mode, input int nbits);
    for (int i = DW-1; i >= DW-nbits; i--) begin
      ser_data = w[i];
      tick(2);
      ser_sck = 1'b1;
      if (i == 0 && mode == 1) begin
        tick(2); ack = 1'b1; tick(1); ack = 1'b0; tick(1);
      end else if (i == 0 && mode == 2) begin
        tick(2);
        chk("strobe_before_done", word_strobe, 0);
        tick(1);
        chk("strobe_rise", word_strobe, 1);
        chk("word_data_first", word_data, w);
        tick(1);
      end else begin
        tick(4);
      end
      ser_sck = 1'b0;
      tick(4);
    end
  endtask

  task automatic start_session();
    ser_cs_n = 1'b0;
    tick(2);
    chk("load_not_early", load, 0);
    tick(1);
    chk("load_rise", load, 1);
    tick(1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 1000 && load; i++) tick(1);
    chk("load_drop", load, 0);
  endtask

  // Loader model: ack each presented word after a delay.
  initial begin
    ack = 1'b0;
    forever begin
      @(posedge clk); #2;
      if (ld_auto && reset && word_strobe) begin
        int d;
        d = ld_rand ? int'($urandom_range(1, 60)) : ld_delay;
        tick(d);
        ack = 1'b1;
        tick(1);
        ack = 1'b0;
      end
    end
  end

  // Monitor: a word is consumed whenever ack meets a valid holding register.
  initial begin
    forever begin
      @(negedge clk);
      if (reset && ack && word_strobe) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_word: got %h expected none", word_data);
        end else begin
          chk("delivered_word", word_data, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    logic [DW-1:0] w, w2;
    reset = 1'b0;
    ser_cs_n = 1'($urandom); ser_sck = 1'($urandom); ser_data = 1'($urandom);
    tick(3);
    chk("rst_load", load, 0);
    chk("rst_strobe", word_strobe, 0);
    chk("rst_data", word_data, 0);
    chk("rst_count", word_count, 0);
    chk("rst_overrun", overrun, 0);
    ser_cs_n = 1'b1; ser_sck = 1'b0; ser_data = 1'b0;
    reset = 1'b1;
    tick(5);
    chk("idle_load", load, 0);

    // single word, manual ack in DRAIN
    start_session();
    exp_q.push_back(16'hA5C3);
    send_word(16'hA5C3, 2, DW);
    ser_cs_n = 1'b1;
    tick(5);
    chk("drain_load", load, 1);
    chk("drain_strobe", word_strobe, 1);
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
    chk("load_fall_after_ack", load, 0);
    chk("strobe_fall_after_ack", word_strobe, 0);
    chk("single_count", word_count, 1);

    // burst 1..8 with back-pressure
    ld_auto = 1'b1; ld_rand = 1'b1;
    start_session();
    for (int i = 1; i <= 8; i++) begin
      exp_q.push_back(DW'(i));
      send_word(DW'(i), 0, DW);
    end
    ser_cs_n = 1'b1;
    wait_idle();
    chk("burst_count", word_count, 8);
    chk("burst_overrun", overrun, 0);
    chk("burst_queue_empty", exp_q.size(), 0);

    // random words
    start_session();
    for (int i = 0; i < 20; i++) begin
      w = DW'($urandom);
      exp_q.push_back(w);
      send_word(w, 0, DW);
    end
    ser_cs_n = 1'b1;
    wait_idle();
    chk("rand_count", word_count, 20);
    chk("rand_overrun", overrun, 0);

    // overrun: three words, no ack
    ld_auto = 1'b0; ld_rand = 1'b0;
    start_session();
    send_word(16'h1111, 0, DW);
    chk("ovr_after1", overrun, 0);
    send_word(16'h2222, 0, DW);
    chk("ovr_after2", overrun, 1);
    send_word(16'h3333, 0, DW);
    chk("ovr_data", word_data, 16'h3333);
    chk("ovr_strobe", word_strobe, 1);
    exp_q.push_back(16'h3333);
    ser_cs_n = 1'b1;
    tick(5);
    ld_auto = 1'b1;
    wait_idle();
    chk("ovr_sticky", overrun, 1);
    chk("ovr_count", word_count, 1);
    start_session();
    chk("ovr_cleared", overrun, 0);
    chk("count_cleared", word_count, 0);
    ser_cs_n = 1'b1;
    wait_idle();

    // ack coincides with completion of word 2
    ld_auto = 1'b0;
    w = DW'($urandom); w2 = DW'($urandom);
    start_session();
    exp_q.push_back(w); exp_q.push_back(w2);
    send_word(w, 0, DW);
    send_word(w2, 1, DW);
    chk("sim_overrun", overrun, 0);
    chk("sim_strobe", word_strobe, 1);
    chk("sim_data", word_data, w2);
    chk("sim_count", word_count, 1);
    ld_auto = 1'b1;
    ser_cs_n = 1'b1;
    wait_idle();
    chk("sim_count_end", word_count, 2);

    // abort after 7 bits, then a clean word
    start_session();
    send_word(DW'($urandom), 0, 7);
    ser_cs_n = 1'b1;
    wait_idle();
    chk("abort_strobe", word_strobe, 0);
    chk("abort_count", word_count, 0);
    w = DW'($urandom);
    start_session();
    exp_q.push_back(w);
    send_word(w, 0, DW);
    ser_cs_n = 1'b1;
    wait_idle();
    chk("post_abort_count", word_count, 1);

    // asynchronous reset mid-word
    ld_auto = 1'b0;
    w = DW'($urandom) | DW'(1);
    start_session();
    send_word(w, 0, DW);
    send_word(DW'($urandom), 0, 8);
    chk("pre_reset_strobe", word_strobe, 1);
    @(negedge clk); #1;
    reset = 1'b0;
    #1;
    chk("async_load", load, 0);
    chk("async_strobe", word_strobe, 0);
    chk("async_data", word_data, 0);
    chk("async_count", word_count, 0);
    chk("async_overrun", overrun, 0);
    tick(2);
    ser_cs_n = 1'b1;
    reset = 1'b1;
    tick(5);
    chk("post_reset_load", load, 0);
    chk("final_queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
